// File: rtl/hazard_control_pkg.sv
// hazard_control_pkg
//   Shared definitions for the hazard control slice: opcode constants,
//   register index width, multiply FSM state encoding and a small helper
//   for register-dependency comparison.
package hazard_control_pkg;

  // Register index width of the integer register file.
  localparam int REG_IDX_W = 5;

  // Opcode constants seen in x_opcode.
  localparam logic [6:0] OPC_MUL    = 7'h02;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // Width of the multiply cycle counter; covers MUL_LATENCY up to 16.
  localparam int MUL_CNT_W = 4;

  // Multi-cycle multiply FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_MUL_LAST = 2'd2
  } hz_state_e;

  // True when a producer register is a real (non-x0) match for a consumer.
  function automatic logic reg_dep(input logic [REG_IDX_W-1:0] producer,
                                   input logic [REG_IDX_W-1:0] consumer);
    return (producer != '0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_control_if.sv
// hazard_control_if
//   Bundles the decode/execute observation signals and the pipeline control
//   returned by the hazard unit.
//   master : pipeline side (drives decode/execute fields, receives control)
//   slave  : hazard unit side (observes fields, drives control)
//   Inputs to hazard unit : d_src_reg_1/2, x_opcode, x_dst_reg, x_mem_read,
//                           x_reg_write, x_redirect, x_target_pc
//   Outputs of hazard unit: f_stall, d_stall, x_stall, fd_flush, dx_flush,
//                           m_bubble, f_redirect, f_redirect_pc, busy,
//                           perf_stall_cnt, perf_flush_cnt
interface hazard_control_if
  import hazard_control_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic [REG_IDX_W-1:0] d_src_reg_1;
  logic [REG_IDX_W-1:0] d_src_reg_2;
  logic [6:0]           x_opcode;
  logic [REG_IDX_W-1:0] x_dst_reg;
  logic                 x_mem_read;
  logic                 x_reg_write;
  logic                 x_redirect;
  logic [31:0]          x_target_pc;

  logic                 f_stall;
  logic                 d_stall;
  logic                 x_stall;
  logic                 fd_flush;
  logic                 dx_flush;
  logic                 m_bubble;
  logic                 f_redirect;
  logic [31:0]          f_redirect_pc;
  logic                 busy;
  logic [CNT_W-1:0]     perf_stall_cnt;
  logic [CNT_W-1:0]     perf_flush_cnt;

  modport master (
    output d_src_reg_1, d_src_reg_2, x_opcode, x_dst_reg, x_mem_read,
           x_reg_write, x_redirect, x_target_pc,
    input  f_stall, d_stall, x_stall, fd_flush, dx_flush, m_bubble,
           f_redirect, f_redirect_pc, busy, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  d_src_reg_1, d_src_reg_2, x_opcode, x_dst_reg, x_mem_read,
           x_reg_write, x_redirect, x_target_pc,
    output f_stall, d_stall, x_stall, fd_flush, dx_flush, m_bubble,
           f_redirect, f_redirect_pc, busy, perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/hazard_control_mul_stall_fsm.sv
// mul_stall_fsm
//   Tracks a multi-cycle multiply sitting in execute and raises mul_stall
//   for MUL_LATENCY-1 cycles. The cycle in MUL_LAST is the one in which the
//   multiply retires, so it is not stalled.
//   clock     : system clock, rising edge
//   reset     : asynchronous active-low reset
//   x_opcode  : execute-stage opcode
//   mul_stall : combinational stall request
//   busy      : FSM is not in IDLE
module mul_stall_fsm
  import hazard_control_pkg::*;
#(
  parameter int         MUL_LATENCY = 3,
  parameter logic [6:0] OPC_MUL     = hazard_control_pkg::OPC_MUL
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] x_opcode,
  output logic       mul_stall,
  output logic       busy
);

  // Counter preload: MUL_BUSY lasts MUL_CNT_INIT+1 cycles.
  localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT =
    (MUL_LATENCY >= 3) ? MUL_CNT_W'(MUL_LATENCY - 3) : '0;
  localparam bit LAT_STALLS = (MUL_LATENCY >= 2);
  localparam bit LAT_BUSY   = (MUL_LATENCY >= 3);

  hz_state_e            state_reg;
  logic [MUL_CNT_W-1:0] mul_cnt_reg;
  logic                 mul_start;

  // Gated by reset so an asserted reset drops the stall in the same cycle
  // even while the multiply opcode is still present in execute.
  assign mul_start = reset && (state_reg == ST_IDLE) && (x_opcode == OPC_MUL);
  assign mul_stall = (mul_start && LAT_STALLS) || (state_reg == ST_MUL_BUSY);
  assign busy      = (state_reg != ST_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      mul_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (mul_start) begin
            if (LAT_BUSY) begin
              state_reg   <= ST_MUL_BUSY;
              mul_cnt_reg <= MUL_CNT_INIT;
            end else if (LAT_STALLS) begin
              state_reg <= ST_MUL_LAST;
            end
          end
        end
        ST_MUL_BUSY: begin
          if (mul_cnt_reg == '0) begin
            state_reg <= ST_MUL_LAST;
          end else begin
            mul_cnt_reg <= mul_cnt_reg - 1'b1;
          end
        end
        // The multiply still occupies execute here; leaving through IDLE
        // on the next edge means it cannot restart itself.
        ST_MUL_LAST: state_reg <= ST_IDLE;
        default:     state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline hazard unit. Watches the decode/execute register outputs and
//   returns stall, flush, bubble and fetch-redirect control. All control is
//   combinational from the multiply FSM state plus current inputs.
//   Priority: multiply stall > execute redirect > load-use.
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   hz    : hazard_control_if.slave (observed fields in, control out)
//   Optional feature macro: HAZARD_PERF_EN enables the stall/flush
//   performance counters; otherwise the counter outputs are tied to 0.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int         MUL_LATENCY = 3,
  parameter logic [6:0] OPC_MUL     = hazard_control_pkg::OPC_MUL,
  parameter int         CNT_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_control_if.slave      hz
);

  logic       mul_stall;
  logic       busy;
  logic [1:0] src_hit;
  logic       load_use;
  logic       redirect_take;

  logic f_stall_next;
  logic d_stall_next;
  logic x_stall_next;
  logic fd_flush_next;
  logic dx_flush_next;
  logic m_bubble_next;
  logic f_redirect_next;

  mul_stall_fsm #(
    .MUL_LATENCY (MUL_LATENCY),
    .OPC_MUL     (OPC_MUL)
  ) u_mul_stall_fsm (
    .clock     (clock),
    .reset     (reset),
    .x_opcode  (hz.x_opcode),
    .mul_stall (mul_stall),
    .busy      (busy)
  );

  // Dependency of each decode-stage source on the execute destination.
  logic [REG_IDX_W-1:0] d_src [2];
  assign d_src[0] = hz.d_src_reg_1;
  assign d_src[1] = hz.d_src_reg_2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src_hit
      assign src_hit[gi] = reg_dep(hz.x_dst_reg, d_src[gi]);
    end
  endgenerate

  assign load_use      = reset && hz.x_mem_read && hz.x_reg_write && (|src_hit);
  // A redirect coinciding with a multiply waits for MUL_LAST, where
  // mul_stall is already low.
  assign redirect_take = reset && hz.x_redirect && !mul_stall;

  always_comb begin
    f_stall_next    = 1'b0;
    d_stall_next    = 1'b0;
    x_stall_next    = 1'b0;
    fd_flush_next   = 1'b0;
    dx_flush_next   = 1'b0;
    m_bubble_next   = 1'b0;
    f_redirect_next = 1'b0;
    if (mul_stall) begin
      f_stall_next  = 1'b1;
      d_stall_next  = 1'b1;
      x_stall_next  = 1'b1;
      m_bubble_next = 1'b1;
    end else if (redirect_take) begin
      // Load-use is ignored: the dependent instruction is squashed anyway.
      f_redirect_next = 1'b1;
      fd_flush_next   = 1'b1;
      dx_flush_next   = 1'b1;
    end else if (load_use) begin
      // One cycle is enough: the bubble now entering execute clears the match.
      f_stall_next  = 1'b1;
      d_stall_next  = 1'b1;
      dx_flush_next = 1'b1;
    end
  end

  assign hz.f_stall       = f_stall_next;
  assign hz.d_stall       = d_stall_next;
  assign hz.x_stall       = x_stall_next;
  assign hz.fd_flush      = fd_flush_next;
  assign hz.dx_flush      = dx_flush_next;
  assign hz.m_bubble      = m_bubble_next;
  assign hz.f_redirect    = f_redirect_next;
  assign hz.f_redirect_pc = hz.x_target_pc;
  assign hz.busy          = busy;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_reg;
  logic [CNT_W-1:0] perf_flush_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      if (f_stall_next) begin
        perf_stall_reg <= perf_stall_reg + CNT_W'(1);
      end
      if (fd_flush_next || dx_flush_next) begin
        perf_flush_reg <= perf_flush_reg + CNT_W'(1);
      end
    end
  end

  assign hz.perf_stall_cnt = perf_stall_reg;
  assign hz.perf_flush_cnt = perf_flush_reg;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule
